// File: rtl/led_pio_pkg.sv
// led_pio_pkg: register addresses and PWM constants shared by the LED PIO
package led_pio_pkg;
   localparam logic [2:0] ADDR_DATA        = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN    = 3'd1;
   localparam logic [2:0] ADDR_HALF_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_DUTY        = 3'd3;
   localparam logic [2:0] ADDR_OUTSET      = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;
   localparam logic [2:0] ADDR_STATUS      = 3'd6;
   localparam int         PWM_PERIOD       = 255;
   localparam logic [7:0] DUTY_FULL        = 8'hFF;
endpackage

// File: rtl/led_pio_blink_timer.sv
// led_pio_blink_timer: half-period prescaler producing the shared blink phase
module led_pio_blink_timer #(
   parameter int PRESCALE_W = 26
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [PRESCALE_W-1:0] half_period,
   input  logic                  restart,
   output logic                  phase
);
   logic [PRESCALE_W-1:0] blink_cnt;
   logic                  tc;

   assign tc = blink_cnt == ((half_period == '0) ? '0 : half_period - PRESCALE_W'(1));

   // count to the terminal value and toggle; a restart zeroes the count but keeps the phase
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (restart)
         blink_cnt <= '0;
      else if (tc) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else
         blink_cnt <= blink_cnt + PRESCALE_W'(1);
endmodule

// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM LED PIO with set/clear, per-bit blink and global PWM dimming
module led_pio_ctrl
   import led_pio_pkg::*;
#(
   parameter int          WIDTH             = 8,
   parameter logic [31:0] RESET_VALUE       = 32'h0F,
   parameter int          PRESCALE_W        = 26,
   parameter int          RESET_HALF_PERIOD = 25_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);
   logic [WIDTH-1:0]      data;
   logic [WIDTH-1:0]      blink_en;
   logic [PRESCALE_W-1:0] half_period;
   logic [7:0]            duty;
   logic [7:0]            pwm_cnt;
   logic [WIDTH-1:0]      wd;
   logic                  we;
   logic                  phase;
   logic                  pwm_on;
   logic                  unused_wd;

   assign we        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign pwm_on    = pwm_cnt < duty;
   assign unused_wd = ^writedata;

   led_pio_blink_timer #(.PRESCALE_W(PRESCALE_W)) u_blink (
      .clk        (clk),
      .reset_n    (reset_n),
      .half_period(half_period),
      .restart    (we && address == ADDR_HALF_PERIOD),
      .phase      (phase)
   );

   // register file; set/clear act on the current DATA so software needs no read-modify-write
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         data        <= RESET_VALUE[WIDTH-1:0];
         blink_en    <= '0;
         half_period <= PRESCALE_W'(RESET_HALF_PERIOD);
         duty        <= DUTY_FULL;
      end else if (we) begin
         if (address == ADDR_DATA)        data        <= wd;
         if (address == ADDR_OUTSET)      data        <= data | wd;
         if (address == ADDR_OUTCLEAR)    data        <= data & ~wd;
         if (address == ADDR_BLINK_EN)    blink_en    <= wd;
         if (address == ADDR_HALF_PERIOD) half_period <= writedata[PRESCALE_W-1:0];
         if (address == ADDR_DUTY)        duty        <= writedata[7:0];
      end

   // free-running PWM counter over 0..PWM_PERIOD-1 so DUTY=FF is always on
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         pwm_cnt <= '0;
      else
         pwm_cnt <= (pwm_cnt == 8'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 8'd1;

   // registered LED drive: pattern gated by blink phase on enabled bits and by the dimmer
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         out_port <= RESET_VALUE[WIDTH-1:0];
      else
         out_port <= data & (~blink_en | {WIDTH{phase}}) & {WIDTH{pwm_on}};

   // combinational read mux; write-only and reserved words read zero
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:        readdata[WIDTH-1:0]      = data;
         ADDR_BLINK_EN:    readdata[WIDTH-1:0]      = blink_en;
         ADDR_HALF_PERIOD: readdata[PRESCALE_W-1:0] = half_period;
         ADDR_DUTY:        readdata[7:0]            = duty;
         ADDR_STATUS:      readdata[0]              = phase;
         default:          readdata                 = '0;
      endcase
   end
endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl: randomized self-checking bench with a closed-form behavioural LED model
module tb_led_pio_ctrl;
   logic        clk = 0, reset_n = 0;
   logic [2:0]  address = 0;
   logic        chipselect = 0, write_n = 1;
   logic [31:0] writedata = 0, readdata;
   logic [7:0]  out_port;
   logic [2:0]  address2 = 0;
   logic        chipselect2 = 0, write_n2 = 1;
   logic [31:0] writedata2 = 0, readdata2, out_port2;

   int total = 0, bad = 0;

   int         n, n_rs, m_hp;
   logic       ph_rs;
   logic [7:0] m_data, m_blink, m_duty, m_out;

   led_pio_ctrl dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   led_pio_ctrl #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .address(address2), .chipselect(chipselect2),
      .write_n(write_n2), .writedata(writedata2), .readdata(readdata2), .out_port(out_port2)
   );

   always #5 clk = ~clk;

   // blink phase after k edges since reset: closed form from the last restart point
   function automatic logic m_ph(int k);
      int hp = (m_hp == 0) ? 1 : m_hp;
      return ph_rs ^ ((((k - n_rs) / hp) % 2) != 0);
   endfunction

   function automatic logic [31:0] m_read(logic [2:0] a);
      case (a)
         3'd0: return {24'b0, m_data};
         3'd1: return {24'b0, m_blink};
         3'd2: return 32'(m_hp);
         3'd3: return {24'b0, m_duty};
         3'd6: return {31'b0, m_ph(n)};
         default: return 32'b0;
      endcase
   endfunction

   // reference model: register semantics plus time-indexed blink and PWM
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         n = 0; n_rs = 0; ph_rs = 1; m_hp = 25_000_000;
         m_data = 8'h0F; m_blink = 0; m_duty = 8'hFF; m_out = 8'h0F;
      end else begin
         m_out = m_data & (~m_blink | {8{m_ph(n)}}) & {8{(n % 255) < int'(m_duty)}};
         if (chipselect && !write_n)
            case (address)
               3'd0: m_data = writedata[7:0];
               3'd1: m_blink = writedata[7:0];
               3'd2: begin ph_rs = m_ph(n); n_rs = n + 1; m_hp = int'(writedata[25:0]); end
               3'd3: m_duty = writedata[7:0];
               3'd4: m_data = m_data | writedata[7:0];
               3'd5: m_data = m_data & ~writedata[7:0];
               default: ;
            endcase
         n++;
      end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1; write_n = 0;
      @(negedge clk);
      chipselect = 0; write_n = 1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1; write_n = 1;
      #1 d = readdata;
      chipselect = 0;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      logic [31:0] exp_rd [5] = '{32'h0F, 32'h0, 32'd25_000_000, 32'hFF, 32'h1};
      logic [2:0]  adr [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      total++;
      if (out_port !== 8'h0F) begin bad++; $display("FAIL reset_out got=%h want=0f", out_port); end
      for (int i = 0; i < 5; i++) begin
         rd(adr[i], v);
         total++;
         if (v !== exp_rd[i]) begin bad++; $display("FAIL reset_rd%0d got=%h want=%h", adr[i], v, exp_rd[i]); end
      end
   endtask

   task automatic test_setclr;
      logic [31:0] v;
      logic [2:0]  adr [3] = '{3'd0, 3'd4, 3'd5};
      logic [31:0] wdv [3] = '{32'hA5, 32'h0A, 32'h21};
      logic [7:0]  exp_d [4] = '{8'h0F, 8'hA5, 8'hAF, 8'h8E};
      for (int i = 0; i < 3; i++) begin
         wr(adr[i], wdv[i]);
         total++;
         if (out_port !== exp_d[i]) begin bad++; $display("FAIL setclr_lat%0d got=%h want=%h", i, out_port, exp_d[i]); end
         rd(3'd0, v);
         total++;
         if (v !== {24'b0, exp_d[i+1]}) begin bad++; $display("FAIL setclr_rd%0d got=%h want=%h", i, v, exp_d[i+1]); end
         total++;
         if (out_port !== exp_d[i+1]) begin bad++; $display("FAIL setclr_out%0d got=%h want=%h", i, out_port, exp_d[i+1]); end
      end
      for (int a = 4; a < 6; a++) begin
         rd(3'(a), v);
         total++;
         if (v !== 0) begin bad++; $display("FAIL wo_rd%0d got=%h want=0", a, v); end
      end
   endtask

   task automatic test_reserved;
      logic [31:0] v;
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd7, v);
      total++;
      if (v !== 0) begin bad++; $display("FAIL rsvd_rd got=%h want=0", v); end
      rd(3'd0, v);
      total++;
      if (v !== 32'h8E) begin bad++; $display("FAIL rsvd_nowrite got=%h want=8e", v); end
   endtask

   task automatic test_blink;
      logic s0;
      wr(3'd2, 4); wr(3'd1, 1); wr(3'd0, 8'hFF);
      @(negedge clk); address = 3'd6; chipselect = 1; write_n = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_port !== m_out) begin bad++; $display("FAIL blink4_out c%0d got=%h want=%h", i, out_port, m_out); end
         total++;
         if (readdata[0] !== m_ph(n)) begin bad++; $display("FAIL blink4_status c%0d got=%b want=%b", i, readdata[0], m_ph(n)); end
      end
      chipselect = 0;
      wr(3'd2, 0);
      address = 3'd6; chipselect = 1; #1 s0 = readdata[0];
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if (readdata[0] !== ~s0 || out_port !== m_out) begin
            bad++; $display("FAIL blink0 c%0d status=%b want=%b out=%h want=%h", i, readdata[0], ~s0, out_port, m_out);
         end
         s0 = readdata[0];
      end
      chipselect = 0;
      wr(3'd2, 4);
      repeat (2) @(negedge clk);
      wr(3'd2, 10);
      address = 3'd6; chipselect = 1; #1 s0 = readdata[0];
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk); #1;
         total++;
         if (readdata[0] !== ((i >= 10) ? ~s0 : s0)) begin
            bad++; $display("FAIL hp10_toggle c%0d got=%b want=%b", i, readdata[0], (i >= 10) ? ~s0 : s0);
         end
      end
      chipselect = 0;
   endtask

   task automatic test_pwm;
      logic [7:0] duties [3] = '{8'd64, 8'd0, 8'd255};
      logic [7:0] expect_hi [3] = '{8'd64, 8'd0, 8'd255};
      int hi;
      wr(3'd1, 0); wr(3'd0, 8'hFF);
      for (int d = 0; d < 3; d++) begin
         wr(3'd3, 32'(duties[d]));
         repeat (2) @(posedge clk);
         hi = 0;
         for (int i = 0; i < 255; i++) begin
            @(posedge clk); #1;
            if (out_port === 8'hFF) hi++;
            total++;
            if (out_port !== m_out || (out_port !== 8'h00 && out_port !== 8'hFF)) begin
               bad++; $display("FAIL pwm%0d_out c%0d got=%h want=%h", duties[d], i, out_port, m_out);
            end
         end
         total++;
         if (hi !== int'(expect_hi[d])) begin bad++; $display("FAIL pwm%0d_count got=%0d want=%0d", duties[d], hi, expect_hi[d]); end
      end
   endtask

   task automatic test_random;
      logic [2:0] a;
      logic       w;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         a = 3'($urandom_range(0, 7));
         w = ($urandom_range(0, 3) == 0);
         address = a; chipselect = 1; write_n = ~w;
         writedata = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
         if ($urandom_range(0, 7) == 0) chipselect = 0;
         #1;
         total++;
         if (readdata !== m_read(a)) begin bad++; $display("FAIL rand_rd it%0d a=%0d got=%h want=%h", i, a, readdata, m_read(a)); end
         @(posedge clk); #1;
         total++;
         if (out_port !== m_out) begin bad++; $display("FAIL rand_out it%0d got=%h want=%h", i, out_port, m_out); end
      end
      @(negedge clk); chipselect = 0; write_n = 1;
   endtask

   task automatic test_width32;
      @(negedge clk);
      address2 = 3'd4; writedata2 = 32'h8000_0001; chipselect2 = 1; write_n2 = 0;
      @(negedge clk);
      chipselect2 = 0; write_n2 = 1;
      @(posedge clk); #1;
      total++;
      if (out_port2 !== 32'h8000_000F) begin bad++; $display("FAIL w32_out got=%h want=8000000f", out_port2); end
      address2 = 3'd0; chipselect2 = 1; #1;
      total++;
      if (readdata2 !== 32'h8000_000F) begin bad++; $display("FAIL w32_rd got=%h want=8000000f", readdata2); end
      chipselect2 = 0;
   endtask

   task automatic test_async_reset;
      logic [31:0] v;
      wr(3'd3, 10); wr(3'd1, 8'hFF); wr(3'd2, 3); wr(3'd0, 8'hFF);
      repeat (7) @(posedge clk);
      #3 reset_n = 0;
      #1;
      total++;
      if (out_port !== 8'h0F) begin bad++; $display("FAIL arst_out got=%h want=0f", out_port); end
      @(negedge clk); reset_n = 1;
      rd(3'd1, v);
      total++;
      if (v !== 0) begin bad++; $display("FAIL arst_blink got=%h want=0", v); end
      rd(3'd3, v);
      total++;
      if (v !== 32'hFF) begin bad++; $display("FAIL arst_duty got=%h want=ff", v); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_port !== 8'h0F || out_port !== m_out) begin bad++; $display("FAIL arst_run c%0d got=%h want=0f", i, out_port); end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1;
      #1;
      test_reset;
      test_setclr;
      test_reserved;
      test_blink;
      test_pwm;
      test_random;
      test_width32;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
